// File: rtl/wb_omi_cmd_master.sv
// wb_omi_cmd_master
// Wishbone classic initiator for the wb_omi_host register/data port.
// Commands are queued in a CMD_DEPTH-entry FIFO and issued one at a time as
// single Wishbone cycles. Every cycle produces exactly one response.
// Optional watchdog: define WB_OMI_CMD_MASTER_TIMEOUT_EN to abandon a cycle
// after TIMEOUT cycles without wb_ack. Without it, BUS waits for wb_ack
// indefinitely, and rsp_err and err_count stay 0.
//
// Handshakes (cmd_* and rsp_*): a transfer happens on a rising clk edge where
// valid && ready. The valid side holds its payload stable until that edge.
// The ready side may change freely.
module wb_omi_cmd_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_we,
    output logic        rsp_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic [31:0] wb_adr,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack,
    input  logic [31:0] wb_dat_i,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int          AW      = $clog2(CMD_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(CMD_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Reject illegal configurations at elaboration time.
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
        TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("wb_omi_cmd_master: CMD_DEPTH must be a power of 2 >= 2, TIMEOUT in 2..65535");
    end

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } cmd_t;

    cmd_t          mem [CMD_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [1:0]    state;
    logic          push;
    logic          pop;
    logic          fifo_nempty;
    logic          timeout_hit;

    assign fifo_nempty = (count != '0);
    assign push        = cmd_valid && cmd_ready;
    // A pop is exactly a transition into BUS: from IDLE, or straight from RESP on handshake.
    assign pop         = fifo_nempty && ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
    assign head        = mem[rd_ptr];
    assign busy        = fifo_nempty || (state != ST_IDLE);

    // Next FIFO occupancy; push and pop in the same cycle cancel out.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage: written on push, no reset needed for the data itself.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{we: cmd_we, adr: cmd_adr, sel: cmd_sel, dat: cmd_dat};
        end
    end

    // FIFO pointers, occupancy, and registered cmd_ready derived from next occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            cmd_ready <= (count_nxt != DEPTH_C);
        end
    end

`ifdef WB_OMI_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;
    logic        rsp_err_q;
    logic [7:0]  err_cnt_q;

    assign timeout_hit = (to_cnt == TO_LAST);
    assign rsp_err     = rsp_err_q;
    assign err_count   = err_cnt_q;

    // Watchdog: counts BUS cycles, flags the response, and counts timeouts (saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt    <= '0;
            rsp_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (pop) begin
                to_cnt <= '0;
            end else if (state == ST_BUS) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (state == ST_BUS && wb_ack) begin
                rsp_err_q <= 1'b0;
            end else if (state == ST_BUS && timeout_hit) begin
                rsp_err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
    assign err_count   = 8'h00;
`endif

    // Main FSM: issue the head command, wait for ack or timeout, hold the response until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_adr    <= '0;
            wb_we     <= 1'b0;
            wb_sel    <= '0;
            wb_dat_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_we    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_BUS;
                end
                ST_BUS: begin
                    // Ack has priority over a timeout in the same cycle.
                    if (wb_ack) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        rsp_dat   <= wb_we ? 32'h0 : wb_dat_i;
                        rsp_we    <= wb_we;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (timeout_hit) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        rsp_dat   <= 32'h0;
                        rsp_we    <= wb_we;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? ST_BUS : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (pop) begin
                wb_cyc   <= 1'b1;
                wb_stb   <= 1'b1;
                wb_adr   <= head.adr;
                wb_we    <= head.we;
                wb_sel   <= head.sel;
                wb_dat_o <= head.dat;
            end
        end
    end

endmodule
